// File: rtl/syn_gpu_mulberry_arb.sv
// Mulberry bus crossbar arbiter: per-slave round-robin issue, MID-routed registered responses.
// Latency 1 cycle request->slv_req and response->mst_rsp_vld; slv_req held until slv_rdy. Optional macro: SYN_GPU_MULBERRY_TMO_EN.
module syn_gpu_mulberry_arb #(
  parameter int P_NUM_MASTERS = 3,
  parameter int P_NUM_SLAVES  = 3,
  parameter int P_DATA_W      = 32,
  parameter int P_TMO_CYCLES  = 255
) (
  input  logic                              clk_ir,
  input  logic                              rst_il,
  input  logic [P_NUM_MASTERS-1:0]          mst_req,
  input  logic [2*P_NUM_MASTERS-1:0]        mst_sid,
  input  logic [P_DATA_W*P_NUM_MASTERS-1:0] mst_data,
  output logic [P_NUM_MASTERS-1:0]          mst_gnt,
  output logic [P_NUM_MASTERS-1:0]          mst_rsp_vld,
  output logic [P_DATA_W*P_NUM_MASTERS-1:0] mst_rsp_data,
  output logic [P_NUM_MASTERS-1:0]          mst_rsp_err,
  output logic [P_NUM_SLAVES-1:0]           slv_req,
  output logic [2*P_NUM_SLAVES-1:0]         slv_mid,
  output logic [P_DATA_W*P_NUM_SLAVES-1:0]  slv_data,
  input  logic [P_NUM_SLAVES-1:0]           slv_rdy,
  input  logic [P_NUM_SLAVES-1:0]           slv_rsp_vld,
  input  logic [2*P_NUM_SLAVES-1:0]         slv_rsp_mid,
  input  logic [P_DATA_W*P_NUM_SLAVES-1:0]  slv_rsp_data
);
  localparam int LP_NM = P_NUM_MASTERS;
  localparam int LP_NS = P_NUM_SLAVES;
  localparam logic [3:0] LP_SID_LEGAL = 4'((1 << (LP_NS + 1)) - 2);

  if (P_TMO_CYCLES < 1 || P_TMO_CYCLES > 255 || LP_NM > 3 || LP_NS > 3) begin : g_cfg_err
    $error("syn_gpu_mulberry_arb: unsupported parameter set");
  end

  typedef enum logic [1:0] {M_IDLE = 2'd0, M_WAIT_SLV = 2'd1, M_WAIT_RSP = 2'd2} mst_st_t;
  typedef enum logic {S_IDLE = 1'b0, S_ISSUE = 1'b1} slv_st_t;

  mst_st_t             r_mst_st   [LP_NM];
  logic [LP_NM-1:0]    r_mst_gnt;
  logic [LP_NM-1:0]    r_rsp_vld;
  logic [LP_NM-1:0]    r_rsp_err;
  logic [P_DATA_W-1:0] r_rsp_data [LP_NM];
  slv_st_t             r_slv_st   [LP_NS];
  logic [LP_NS-1:0]    r_slv_req;
  logic [1:0]          r_slv_mid  [LP_NS];
  logic [P_DATA_W-1:0] r_slv_data [LP_NS];
  logic [1:0]          r_rr_ptr   [LP_NS];
`ifdef SYN_GPU_MULBERRY_TMO_EN
  localparam logic [7:0] LP_TMO_LAST = 8'(P_TMO_CYCLES - 1);
  logic [7:0]          r_tmo_cnt  [LP_NM];
`endif

  logic [LP_NM-1:0]    w_elig, w_ill, w_cap, w_gnt_nxt, w_rsp_hit;
  logic [P_DATA_W-1:0] w_rsp_dat  [LP_NM];
  logic [LP_NS-1:0]    w_win_vld;
  logic [1:0]          w_win_idx  [LP_NS];

  // The grant cycle is the last cycle a master may still hold mst_req, so it is not eligible then.
  always_comb begin
    for (int i = 0; i < LP_NM; i++) begin
      w_elig[i] = (r_mst_st[i] == M_IDLE) && mst_req[i] && !r_mst_gnt[i];
      w_ill[i]  = w_elig[i] && !LP_SID_LEGAL[mst_sid[2*i +: 2]];
    end
  end

  always_comb begin
    int   m;
    logic found;
    m     = 0;
    found = 1'b0;
    for (int j = 0; j < LP_NS; j++) begin
      w_win_vld[j] = 1'b0;
      w_win_idx[j] = 2'd0;
      found        = 1'b0;
      for (int k = 0; k < LP_NM; k++) begin
        m = (int'(r_rr_ptr[j]) + k) % LP_NM;
        if (r_slv_st[j] == S_IDLE && !found && w_elig[m] && mst_sid[2*m +: 2] == 2'(j + 1)) begin
          found        = 1'b1;
          w_win_vld[j] = 1'b1;
          w_win_idx[j] = 2'(m);
        end
      end
    end
  end

  always_comb begin
    for (int i = 0; i < LP_NM; i++) begin
      w_cap[i]     = 1'b0;
      w_gnt_nxt[i] = 1'b0;
      for (int j = 0; j < LP_NS; j++) begin
        if (w_win_vld[j] && w_win_idx[j] == 2'(i))
          w_cap[i] = 1'b1;
        if (r_slv_st[j] == S_ISSUE && slv_rdy[j] && r_slv_mid[j] == 2'(i + 1))
          w_gnt_nxt[i] = 1'b1;
      end
    end
  end

  // Lowest responding slave claims the master; a zero-wait slave may answer in its accept cycle.
  always_comb begin
    logic found;
    found = 1'b0;
    for (int i = 0; i < LP_NM; i++) begin
      w_rsp_hit[i] = 1'b0;
      w_rsp_dat[i] = '0;
      found        = 1'b0;
      for (int j = 0; j < LP_NS; j++) begin
        if (!found && slv_rsp_vld[j] && slv_rsp_mid[2*j +: 2] == 2'(i + 1)) begin
          found        = 1'b1;
          w_rsp_hit[i] = (r_mst_st[i] == M_WAIT_RSP) || (r_mst_st[i] == M_WAIT_SLV && w_gnt_nxt[i]);
          w_rsp_dat[i] = slv_rsp_data[P_DATA_W*j +: P_DATA_W];
        end
      end
    end
  end

  always_ff @(posedge clk_ir or negedge rst_il) begin
    if (!rst_il) begin
      r_mst_gnt <= '0;
      r_rsp_vld <= '0;
      r_rsp_err <= '0;
      for (int i = 0; i < LP_NM; i++) begin
        r_mst_st[i]   <= M_IDLE;
        r_rsp_data[i] <= '0;
`ifdef SYN_GPU_MULBERRY_TMO_EN
        r_tmo_cnt[i]  <= 8'd0;
`endif
      end
    end else begin
      for (int i = 0; i < LP_NM; i++) begin
        r_mst_gnt[i]  <= w_gnt_nxt[i] || w_ill[i];
        r_rsp_vld[i]  <= 1'b0;
        r_rsp_err[i]  <= 1'b0;
        r_rsp_data[i] <= '0;
        case (r_mst_st[i])
          M_IDLE: begin
            if (w_ill[i]) begin
              r_rsp_vld[i] <= 1'b1;
              r_rsp_err[i] <= 1'b1;
            end else if (w_cap[i]) begin
              r_mst_st[i] <= M_WAIT_SLV;
            end
          end
          M_WAIT_SLV: begin
            if (w_gnt_nxt[i]) begin
              if (w_rsp_hit[i]) begin
                r_rsp_vld[i]  <= 1'b1;
                r_rsp_data[i] <= w_rsp_dat[i];
                r_mst_st[i]   <= M_IDLE;
              end else begin
                r_mst_st[i]   <= M_WAIT_RSP;
              end
`ifdef SYN_GPU_MULBERRY_TMO_EN
              r_tmo_cnt[i] <= 8'd0;
`endif
            end
          end
          M_WAIT_RSP: begin
            if (w_rsp_hit[i]) begin
              r_rsp_vld[i]  <= 1'b1;
              r_rsp_data[i] <= w_rsp_dat[i];
              r_mst_st[i]   <= M_IDLE;
            end
`ifdef SYN_GPU_MULBERRY_TMO_EN
            else if (r_tmo_cnt[i] == LP_TMO_LAST) begin
              r_rsp_vld[i] <= 1'b1;
              r_rsp_err[i] <= 1'b1;
              r_mst_st[i]  <= M_IDLE;
            end else begin
              r_tmo_cnt[i] <= r_tmo_cnt[i] + 8'd1;
            end
`endif
          end
          default: r_mst_st[i] <= M_IDLE;
        endcase
      end
    end
  end

  always_ff @(posedge clk_ir or negedge rst_il) begin
    if (!rst_il) begin
      r_slv_req <= '0;
      for (int j = 0; j < LP_NS; j++) begin
        r_slv_st[j]   <= S_IDLE;
        r_slv_mid[j]  <= 2'd0;
        r_slv_data[j] <= '0;
        r_rr_ptr[j]   <= 2'd0;
      end
    end else begin
      for (int j = 0; j < LP_NS; j++) begin
        case (r_slv_st[j])
          S_IDLE: begin
            if (w_win_vld[j]) begin
              r_slv_st[j]   <= S_ISSUE;
              r_slv_req[j]  <= 1'b1;
              r_slv_mid[j]  <= w_win_idx[j] + 2'd1;
              r_slv_data[j] <= mst_data[P_DATA_W*int'(w_win_idx[j]) +: P_DATA_W];
            end
          end
          S_ISSUE: begin
            if (slv_rdy[j]) begin
              r_slv_st[j]   <= S_IDLE;
              r_slv_req[j]  <= 1'b0;
              r_slv_mid[j]  <= 2'd0;
              r_slv_data[j] <= '0;
              // mid already equals winner+1; wrap past the last master
              r_rr_ptr[j]   <= (int'(r_slv_mid[j]) >= LP_NM) ? 2'd0 : r_slv_mid[j];
            end
          end
          default: r_slv_st[j] <= S_IDLE;
        endcase
      end
    end
  end

  assign mst_gnt     = r_mst_gnt;
  assign mst_rsp_vld = r_rsp_vld;
  assign mst_rsp_err = r_rsp_err;
  assign slv_req     = r_slv_req;

  for (genvar gi = 0; gi < LP_NM; gi++) begin : g_mst_out
    assign mst_rsp_data[P_DATA_W*gi +: P_DATA_W] = r_rsp_data[gi];
  end
  for (genvar gj = 0; gj < LP_NS; gj++) begin : g_slv_out
    assign slv_mid[2*gj +: 2]             = r_slv_mid[gj];
    assign slv_data[P_DATA_W*gj +: P_DATA_W] = r_slv_data[gj];
  end

endmodule

// File: tb/tb_syn_gpu_mulberry_arb.sv
// Scoreboard bench for syn_gpu_mulberry_arb: directed phases push expected events, a negedge monitor pops them.
// Covers reset, contention, parallel issue, backpressure, routing, collisions, zero-wait, illegal SID, timeout.
module tb_syn_gpu_mulberry_arb;
  localparam int NM = 3;
  localparam int NS = 3;
  localparam int W  = 32;

  logic            clk_ir = 1'b0;
  logic            rst_il = 1'b0;
  logic [NM-1:0]   mst_req;
  logic [2*NM-1:0] mst_sid;
  logic [W*NM-1:0] mst_data;
  logic [NM-1:0]   mst_gnt, mst_rsp_vld, mst_rsp_err;
  logic [W*NM-1:0] mst_rsp_data;
  logic [NS-1:0]   slv_req;
  logic [2*NS-1:0] slv_mid;
  logic [W*NS-1:0] slv_data;
  logic [NS-1:0]   slv_rdy, slv_rsp_vld;
  logic [2*NS-1:0] slv_rsp_mid;
  logic [W*NS-1:0] slv_rsp_data;

  syn_gpu_mulberry_arb #(.P_NUM_MASTERS(NM), .P_NUM_SLAVES(NS), .P_DATA_W(W), .P_TMO_CYCLES(255)) dut (
    .clk_ir(clk_ir), .rst_il(rst_il),
    .mst_req(mst_req), .mst_sid(mst_sid), .mst_data(mst_data),
    .mst_gnt(mst_gnt), .mst_rsp_vld(mst_rsp_vld), .mst_rsp_data(mst_rsp_data), .mst_rsp_err(mst_rsp_err),
    .slv_req(slv_req), .slv_mid(slv_mid), .slv_data(slv_data), .slv_rdy(slv_rdy),
    .slv_rsp_vld(slv_rsp_vld), .slv_rsp_mid(slv_rsp_mid), .slv_rsp_data(slv_rsp_data)
  );

  always #5 clk_ir = ~clk_ir;

  // kind: 0 = slave accept (idx = slave), 1 = master grant, 2 = master response
  typedef struct packed {
    logic [1:0]  kind;
    logic [1:0]  idx;
    logic [1:0]  mid;
    logic [31:0] dat;
    logic        err;
  } ev_t;

  ev_t exp_q[$];
  int  n_chk = 0;
  int  n_err = 0;

  function automatic ev_t mk(int k, int idx, int mid, logic [31:0] d, logic e);
    ev_t v;
    v.kind = 2'(k);
    v.idx  = 2'(idx);
    v.mid  = 2'(mid);
    v.dat  = d;
    v.err  = e;
    return v;
  endfunction

  task automatic sb_got(ev_t got);
    ev_t e;
    n_chk++;
    if (exp_q.size() == 0) begin
      n_err++;
      $display("FAIL sb_unexpected: got kind=%0d idx=%0d mid=%0d dat=%h err=%0d, required no event",
               got.kind, got.idx, got.mid, got.dat, got.err);
    end else begin
      e = exp_q.pop_front();
      if (e !== got) begin
        n_err++;
        $display("FAIL sb_event: got kind=%0d idx=%0d mid=%0d dat=%h err=%0d, required kind=%0d idx=%0d mid=%0d dat=%h err=%0d",
                 got.kind, got.idx, got.mid, got.dat, got.err, e.kind, e.idx, e.mid, e.dat, e.err);
      end
    end
  endtask

  always @(negedge clk_ir) begin
    if (rst_il) begin
      for (int j = 0; j < NS; j++)
        if (slv_req[j] && slv_rdy[j]) sb_got(mk(0, j, int'(slv_mid[2*j +: 2]), slv_data[W*j +: W], 1'b0));
      for (int i = 0; i < NM; i++)
        if (mst_gnt[i]) sb_got(mk(1, i, 0, 32'h0, 1'b0));
      for (int i = 0; i < NM; i++)
        if (mst_rsp_vld[i]) sb_got(mk(2, i, 0, mst_rsp_data[W*i +: W], mst_rsp_err[i]));
    end
  end

  task automatic chk(string nm, logic [63:0] act, logic [63:0] req);
    n_chk++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %h required %h", nm, act, req);
    end
  endtask

  function automatic logic [14:0] outs();
    return {mst_gnt, mst_rsp_vld, mst_rsp_err, |mst_rsp_data, slv_req, |slv_mid, |slv_data};
  endfunction

  // A master keeps mst_req through its grant cycle and drops it afterwards.
  task automatic tick(int n = 1);
    for (int c = 0; c < n; c++) begin
      logic [NM-1:0] g;
      @(negedge clk_ir);
      g = mst_gnt;
      @(posedge clk_ir);
      #1;
      mst_req = mst_req & ~g;
    end
  endtask

  task automatic req_set(int i, int sid, logic [31:0] d);
    mst_req[i]          = 1'b1;
    mst_sid[2*i +: 2]   = 2'(sid);
    mst_data[W*i +: W]  = d;
  endtask

  task automatic rsp_set(int j, int mid, logic [31:0] d);
    slv_rsp_vld[j]          = 1'b1;
    slv_rsp_mid[2*j +: 2]   = 2'(mid);
    slv_rsp_data[W*j +: W]  = d;
  endtask

  task automatic rsp_clr();
    slv_rsp_vld  = '0;
    slv_rsp_mid  = '0;
    slv_rsp_data = '0;
  endtask

  task automatic drain(int budget);
    int c;
    c = 0;
    while (exp_q.size() != 0 && c < budget) begin
      tick();
      c++;
    end
    if (exp_q.size() != 0) begin
      n_chk++;
      n_err++;
      $display("FAIL drain_timeout: %0d events pending, required 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  initial begin
    mst_req  = '0;
    mst_sid  = '0;
    mst_data = '0;
    slv_rdy  = '1;
    rsp_clr();
    repeat (3) @(posedge clk_ir);
    #1;
    chk("reset_state", 64'(outs()), 64'h0);
    rst_il = 1'b1;
    tick(2);

    // contention on SID_MUL: round robin 1,2,3
    exp_q.push_back(mk(0, 1, 1, 32'hA000_0000, 1'b0));
    exp_q.push_back(mk(1, 0, 0, 32'h0, 1'b0));
    exp_q.push_back(mk(0, 1, 2, 32'hA000_0001, 1'b0));
    exp_q.push_back(mk(1, 1, 0, 32'h0, 1'b0));
    exp_q.push_back(mk(0, 1, 3, 32'hA000_0002, 1'b0));
    exp_q.push_back(mk(1, 2, 0, 32'h0, 1'b0));
    req_set(0, 2, 32'hA000_0000);
    req_set(1, 2, 32'hA000_0001);
    req_set(2, 2, 32'hA000_0002);
    drain(40);
    // three slaves answer three different masters in one cycle
    exp_q.push_back(mk(2, 0, 0, 32'hB000_0000, 1'b0));
    exp_q.push_back(mk(2, 1, 0, 32'hB000_0001, 1'b0));
    exp_q.push_back(mk(2, 2, 0, 32'hB000_0002, 1'b0));
    rsp_set(0, 1, 32'hB000_0000);
    rsp_set(1, 2, 32'hB000_0001);
    rsp_set(2, 3, 32'hB000_0002);
    tick();
    rsp_clr();
    drain(10);
    tick(3);

    // routing via SID_DIV, plus responses to an idle master and to MID_IDLE
    exp_q.push_back(mk(0, 2, 2, 32'hC000_0001, 1'b0));
    exp_q.push_back(mk(1, 1, 0, 32'h0, 1'b0));
    req_set(1, 3, 32'hC000_0001);
    drain(20);
    exp_q.push_back(mk(2, 1, 0, 32'hDEAD_BEEF, 1'b0));
    rsp_set(2, 2, 32'hDEAD_BEEF);
    rsp_set(0, 1, 32'h1111_1111);
    rsp_set(1, 0, 32'h2222_2222);
    tick();
    rsp_clr();
    drain(10);
    tick(3);

    // two slaves answer the same master: slave 0 wins
    exp_q.push_back(mk(0, 1, 3, 32'hC000_0002, 1'b0));
    exp_q.push_back(mk(1, 2, 0, 32'h0, 1'b0));
    req_set(2, 2, 32'hC000_0002);
    drain(20);
    exp_q.push_back(mk(2, 2, 0, 32'h3333_3333, 1'b0));
    rsp_set(0, 3, 32'h3333_3333);
    rsp_set(1, 3, 32'h4444_4444);
    tick();
    rsp_clr();
    drain(10);
    tick(3);

    // parallel issue to SID_RAND and SID_DIV
    exp_q.push_back(mk(0, 0, 1, 32'hD000_0000, 1'b0));
    exp_q.push_back(mk(0, 2, 2, 32'hD000_0001, 1'b0));
    exp_q.push_back(mk(1, 0, 0, 32'h0, 1'b0));
    exp_q.push_back(mk(1, 1, 0, 32'h0, 1'b0));
    req_set(0, 1, 32'hD000_0000);
    req_set(1, 3, 32'hD000_0001);
    tick();
    chk("parallel_slv_req", 64'(slv_req), 64'h5);
    drain(20);
    exp_q.push_back(mk(2, 0, 0, 32'hE000_0000, 1'b0));
    exp_q.push_back(mk(2, 1, 0, 32'hE000_0001, 1'b0));
    rsp_set(0, 1, 32'hE000_0000);
    rsp_set(2, 2, 32'hE000_0001);
    tick();
    rsp_clr();
    drain(10);
    tick(3);

    // backpressure: slv_rdy low for 5 cycles on SID_MUL
    slv_rdy[1] = 1'b0;
    exp_q.push_back(mk(0, 1, 1, 32'h0000_1234, 1'b0));
    exp_q.push_back(mk(1, 0, 0, 32'h0, 1'b0));
    req_set(0, 2, 32'h0000_1234);
    tick();
    for (int k = 0; k < 5; k++) begin
      chk("bp_hold", 64'({slv_req[1], slv_mid[3:2], slv_data[63:32], mst_gnt[0]}),
          64'({1'b1, 2'd1, 32'h0000_1234, 1'b0}));
      tick();
    end
    slv_rdy[1] = 1'b1;
    tick();
    chk("bp_gnt_after_rdy", 64'({mst_gnt[0], slv_req[1]}), 64'h2);
    drain(10);
    exp_q.push_back(mk(2, 0, 0, 32'hF000_0000, 1'b0));
    rsp_set(1, 1, 32'hF000_0000);
    tick();
    rsp_clr();
    drain(10);
    tick(3);

    // zero-wait slave: response in the accept cycle
    exp_q.push_back(mk(0, 1, 3, 32'h0000_0066, 1'b0));
    exp_q.push_back(mk(1, 2, 0, 32'h0, 1'b0));
    exp_q.push_back(mk(2, 2, 0, 32'h0000_0077, 1'b0));
    req_set(2, 2, 32'h0000_0066);
    tick();
    rsp_set(1, 3, 32'h0000_0077);
    tick();
    rsp_clr();
    chk("zero_wait_gnt_rsp", 64'({mst_gnt[2], mst_rsp_vld[2]}), 64'h3);
    drain(10);
    tick(3);

    // illegal SID
    exp_q.push_back(mk(1, 1, 0, 32'h0, 1'b0));
    exp_q.push_back(mk(2, 1, 0, 32'h0, 1'b1));
    req_set(1, 0, 32'h5555_5555);
    tick();
    chk("illegal_sid", 64'({mst_gnt[1], mst_rsp_vld[1], mst_rsp_err[1], mst_rsp_data[63:32]}),
        64'({3'b111, 32'h0}));
    drain(10);
    tick(3);

`ifdef SYN_GPU_MULBERRY_TMO_EN
    begin
      int cnt;
      exp_q.push_back(mk(0, 0, 1, 32'h0000_0088, 1'b0));
      exp_q.push_back(mk(1, 0, 0, 32'h0, 1'b0));
      exp_q.push_back(mk(2, 0, 0, 32'h0, 1'b1));
      req_set(0, 1, 32'h0000_0088);
      cnt = 0;
      while (!mst_gnt[0] && cnt < 20) begin
        tick();
        cnt++;
      end
      cnt = 0;
      while (!mst_rsp_vld[0] && cnt < 400) begin
        tick();
        cnt++;
      end
      chk("tmo_latency", 64'(cnt), 64'd255);
      drain(10);
      rsp_set(0, 1, 32'h9999_9999);
      tick();
      rsp_clr();
      tick(3);
    end
`endif

    // move SID_MUL pointer off master 0, then reset mid-ISSUE
    exp_q.push_back(mk(0, 1, 1, 32'h0000_00A0, 1'b0));
    exp_q.push_back(mk(1, 0, 0, 32'h0, 1'b0));
    req_set(0, 2, 32'h0000_00A0);
    drain(20);
    slv_rdy[1] = 1'b0;
    req_set(1, 2, 32'h0000_00A1);
    tick(2);
    chk("issue_before_rst", 64'(slv_req[1]), 64'h1);
    rst_il = 1'b0;
    #1;
    chk("rst_async_outputs", 64'(outs()), 64'h0);
    mst_req = '0;
    slv_rdy = '1;
    tick(2);
    rst_il = 1'b1;
    tick();
    exp_q.push_back(mk(0, 1, 1, 32'h0000_00B0, 1'b0));
    exp_q.push_back(mk(1, 0, 0, 32'h0, 1'b0));
    exp_q.push_back(mk(0, 1, 2, 32'h0000_00B1, 1'b0));
    exp_q.push_back(mk(1, 1, 0, 32'h0, 1'b0));
    req_set(0, 2, 32'h0000_00B0);
    req_set(1, 2, 32'h0000_00B1);
    drain(30);
    tick(3);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
